// File: rtl/control_unit.sv
// Multi-cycle decode/sequencing controller feeding the 8-bit ALU and register file.
// Accepts one instruction per handshake, holds decoded controls, then pulses WRITEENABLE.
module control_unit #(
    parameter int unsigned ADD_CYCLES   = 2,
    parameter int unsigned LOGIC_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic [7:0]  IMMEDIATE,
    output logic [2:0]  ALUOP,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        WRITEENABLE,
    output logic        BUSY,
    output logic        ILLEGAL
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    localparam logic [3:0] ADD_K   = 4'(ADD_CYCLES);
    localparam logic [3:0] LOGIC_K = 4'(LOGIC_CYCLES);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] rr1_q, rr1_d, rr2_q, rr2_d, wr_q, wr_d, aluop_q, aluop_d;
    logic [7:0] imm_q, imm_d;
    logic       imm_sel_q, imm_sel_d, neg_sel_q, neg_sel_d;
    logic       we_q, we_d, ill_q, ill_d;
    logic [7:0] opcode;

    assign opcode = INSTRUCTION[31:24];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr1_d     = rr1_q;
        rr2_d     = rr2_q;
        wr_d      = wr_q;
        imm_d     = imm_q;
        aluop_d   = aluop_q;
        imm_sel_d = imm_sel_q;
        neg_sel_d = neg_sel_q;
        we_d      = 1'b0;
        ill_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (INSTR_VALID) begin
                    // Decode straight into the output registers so they are valid in DECODE.
                    state_d   = S_DECODE;
                    rr1_d     = INSTRUCTION[10:8];
                    rr2_d     = INSTRUCTION[2:0];
                    wr_d      = INSTRUCTION[18:16];
                    imm_d     = INSTRUCTION[7:0];
                    aluop_d   = OP_FWD;
                    imm_sel_d = 1'b0;
                    neg_sel_d = 1'b0;
                    case (opcode)
                        8'h00: begin imm_sel_d = 1'b1; rr2_d = 3'd0; end
                        8'h01: ;
                        8'h02: aluop_d = OP_ADD;
                        8'h03: begin aluop_d = OP_ADD; neg_sel_d = 1'b1; end
                        8'h04: aluop_d = OP_AND;
                        8'h05: aluop_d = OP_OR;
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            S_DECODE: begin
                if (ill_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                    cnt_d   = (aluop_q == OP_ADD) ? ADD_K : LOGIC_K;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_WB;
                    cnt_d   = 4'd0;
                    we_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rr1_q     <= 3'd0;
            rr2_q     <= 3'd0;
            wr_q      <= 3'd0;
            imm_q     <= 8'd0;
            aluop_q   <= OP_FWD;
            imm_sel_q <= 1'b0;
            neg_sel_q <= 1'b0;
            we_q      <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr1_q     <= rr1_d;
            rr2_q     <= rr2_d;
            wr_q      <= wr_d;
            imm_q     <= imm_d;
            aluop_q   <= aluop_d;
            imm_sel_q <= imm_sel_d;
            neg_sel_q <= neg_sel_d;
            we_q      <= we_d;
            ill_q     <= ill_d;
        end
    end

    assign INSTR_READY = (state_q == S_IDLE);
    assign BUSY        = (state_q != S_IDLE);
    assign READREG1    = rr1_q;
    assign READREG2    = rr2_q;
    assign WRITEREG    = wr_q;
    assign IMMEDIATE   = imm_q;
    assign ALUOP       = aluop_q;
    assign IMM_SEL     = imm_sel_q;
    assign NEG_SEL     = neg_sel_q;
    assign WRITEENABLE = we_q;
    assign ILLEGAL     = ill_q;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: transaction-level timeline model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_control_unit;
    localparam int ADD_K   = 2;
    localparam int LOGIC_K = 1;

    logic        CLK = 1'b0, RESET = 1'b0, INSTR_VALID = 1'b0;
    logic [31:0] INSTRUCTION = 32'd0;
    logic        INSTR_READY, IMM_SEL, NEG_SEL, WRITEENABLE, BUSY, ILLEGAL;
    logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
    logic [7:0]  IMMEDIATE;

    control_unit #(.ADD_CYCLES(ADD_K), .LOGIC_CYCLES(LOGIC_K)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .READREG1(READREG1), .READREG2(READREG2),
        .WRITEREG(WRITEREG), .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
        .NEG_SEL(NEG_SEL), .WRITEENABLE(WRITEENABLE), .BUSY(BUSY), .ILLEGAL(ILLEGAL));

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since acceptance (0 = idle); the instruction occupies
    // cycles 1..last where last = 2+k for legal ops and 1 for illegal ones.
    int         m_t = 0, m_k = 0;
    bit         m_legal = 1'b0;
    logic [2:0] m_rr1 = 0, m_rr2 = 0, m_wr = 0, m_alu = 0;
    logic [7:0] m_imm = 0;
    logic       m_isel = 0, m_nsel = 0;

    function automatic int m_last();
        return m_legal ? 2 + m_k : 1;
    endfunction

    initial forever begin
        @(posedge CLK or negedge RESET);
        if (!RESET) begin
            m_t = 0; m_k = 0; m_legal = 0;
            m_rr1 = 0; m_rr2 = 0; m_wr = 0; m_alu = 0; m_imm = 0; m_isel = 0; m_nsel = 0;
        end else if (m_t == 0) begin
            if (INSTR_VALID) begin
                m_t = 1; m_legal = 1; m_isel = 0; m_nsel = 0; m_alu = 3'd0; m_k = LOGIC_K;
                m_rr1 = INSTRUCTION[10:8]; m_rr2 = INSTRUCTION[2:0];
                m_wr = INSTRUCTION[18:16]; m_imm = INSTRUCTION[7:0];
                case (INSTRUCTION[31:24])
                    8'h00: begin m_isel = 1; m_rr2 = 0; end
                    8'h01: ;
                    8'h02: begin m_alu = 3'd1; m_k = ADD_K; end
                    8'h03: begin m_alu = 3'd1; m_nsel = 1; m_k = ADD_K; end
                    8'h04: m_alu = 3'd2;
                    8'h05: m_alu = 3'd3;
                    default: m_legal = 0;
                endcase
            end
        end else if (m_t == m_last()) begin
            m_t = 0;
        end else begin
            m_t++;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_ready", INSTR_READY, m_t == 0);
            chk("m_busy", BUSY, m_t != 0);
            chk("m_we", WRITEENABLE, m_legal && m_t == 2 + m_k);
            chk("m_illegal", ILLEGAL, !m_legal && m_t == 1);
            chk("m_rr1", READREG1, m_rr1);
            chk("m_rr2", READREG2, m_rr2);
            chk("m_wr", WRITEREG, m_wr);
            chk("m_imm", IMMEDIATE, m_imm);
            chk("m_aluop", ALUOP, m_alu);
            chk("m_imm_sel", IMM_SEL, m_isel);
            chk("m_neg_sel", NEG_SEL, m_nsel);
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!INSTR_READY && n < 50) begin step(); n++; end
        if (!INSTR_READY) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Present one instruction for exactly one edge; returns in cycle N+1.
    task automatic issue(input logic [31:0] ins);
        wait_idle();
        INSTRUCTION = ins; INSTR_VALID = 1'b1;
        step();
        INSTR_VALID = 1'b0;
    endtask

    int pulses;
    logic [2:0] wr_seen [2];

    initial begin
        step(); step();
        chk_en = 1'b1;
        chk("rst_ready", INSTR_READY, 1); chk("rst_we", WRITEENABLE, 0);
        chk("rst_aluop", ALUOP, 0); chk("rst_wr", WRITEREG, 0);
        RESET = 1'b1;
        step();

        // loadi: N+1 decode, WE only in N+3, ready in N+4
        issue(32'h00_03_00_2A);
        chk("ldi_wr", WRITEREG, 3); chk("ldi_imm", IMMEDIATE, 8'h2A);
        chk("ldi_alu", ALUOP, 0); chk("ldi_isel", IMM_SEL, 1); chk("ldi_rr2", READREG2, 0);
        chk("ldi_we1", WRITEENABLE, 0);
        step(); chk("ldi_we2", WRITEENABLE, 0);
        step(); chk("ldi_we3", WRITEENABLE, 1);
        step(); chk("ldi_we4", WRITEENABLE, 0); chk("ldi_rdy4", INSTR_READY, 1);

        // sub: WE only in N+4
        issue(32'h03_05_01_02);
        chk("sub_rr1", READREG1, 1); chk("sub_rr2", READREG2, 2); chk("sub_wr", WRITEREG, 5);
        chk("sub_alu", ALUOP, 1); chk("sub_nsel", NEG_SEL, 1); chk("sub_isel", IMM_SEL, 0);
        step(); chk("sub_we2", WRITEENABLE, 0);
        step(); chk("sub_we3", WRITEENABLE, 0);
        step(); chk("sub_we4", WRITEENABLE, 1);
        step(); chk("sub_rdy5", INSTR_READY, 1);

        // illegal opcode
        issue(32'h07_01_02_03);
        chk("ill_pulse", ILLEGAL, 1); chk("ill_we", WRITEENABLE, 0); chk("ill_alu", ALUOP, 0);
        step(); chk("ill_clr", ILLEGAL, 0); chk("ill_rdy", INSTR_READY, 1);
        chk("ill_we2", WRITEENABLE, 0);

        // back-to-back and/or with VALID held high
        wait_idle();
        INSTRUCTION = 32'h04_01_02_03; INSTR_VALID = 1'b1;
        pulses = 0;
        step();
        INSTRUCTION = 32'h05_04_01_02;
        for (int c = 1; c <= 10; c++) begin
            if (WRITEENABLE) begin
                if (pulses < 2) wr_seen[pulses] = WRITEREG;
                pulses++;
            end
            if (c == 4) begin chk("b2b_rdy", INSTR_READY, 1); chk("b2b_busy", BUSY, 0); end
            if (c == 5) begin
                chk("b2b_wr2", WRITEREG, 4); chk("b2b_alu2", ALUOP, 3);
                INSTR_VALID = 1'b0;
            end
            step();
        end
        chk("b2b_pulses", pulses, 2);
        chk("b2b_first", wr_seen[0], 1);
        chk("b2b_second", wr_seen[1], 4);

        // field masking; inputs toggled during EXEC/WRITEBACK are ignored
        issue(32'h01_F9_FA_FB);
        chk("mov_wr", WRITEREG, 1); chk("mov_rr1", READREG1, 2); chk("mov_rr2", READREG2, 3);
        chk("mov_imm", IMMEDIATE, 8'hFB);
        step();
        INSTRUCTION = 32'h05_02_03_04; INSTR_VALID = 1'b1;
        step();
        INSTR_VALID = 1'b0;
        chk("mov_hold_wr", WRITEREG, 1); chk("mov_hold_alu", ALUOP, 0);
        chk("mov_we", WRITEENABLE, 1);
        step(); chk("mov_after", WRITEREG, 1); chk("mov_rdy", INSTR_READY, 1);

        // reset mid-EXEC of an add
        issue(32'h02_02_01_01);
        step();
        chk("rst_in_exec", BUSY, 1);
        #1 RESET = 1'b0;
        #1;
        chk("arst_we", WRITEENABLE, 0); chk("arst_busy", BUSY, 0); chk("arst_ready", INSTR_READY, 1);
        chk("arst_alu", ALUOP, 0); chk("arst_wr", WRITEREG, 0); chk("arst_rr1", READREG1, 0);
        chk("arst_imm", IMMEDIATE, 0);
        step(); step();
        RESET = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (WRITEENABLE) pulses++;
            step();
        end
        chk("arst_no_we", pulses, 0);
        chk("arst_ready_after", INSTR_READY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction decode/sequencing stage sitting directly upstream of the 8-bit ALU and register file. Accepts one 32-bit instruction per handshake, decodes it into register addresses, immediate, ALU select and operand-mux controls, holds them stable while the ALU settles, then issues a single-cycle register write-enable. Replaces the hard-wired ALU SELECT stimulus with a sequenced controller.

## Interface
- ADD_CYCLES, 2, EXEC-state cycles for add/sub (ALU adder path); legal 1–15
- LOGIC_CYCLES, 1, EXEC-state cycles for forward/and/or; legal 1–15
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- INSTRUCTION  in  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/immediate
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle
- INSTR_READY  out  1  controller can accept an instruction
- READREG1  out  3  register-file read address 1 (src1[2:0])
- READREG2  out  3  register-file read address 2 (src2[2:0])
- WRITEREG  out  3  destination register (dest[2:0])
- IMMEDIATE  out  8  INSTRUCTION[7:0] of accepted instruction
- ALUOP  out  3  ALU SELECT (000 fwd, 001 add, 010 and, 011 or)
- IMM_SEL  out  1  1 = ALU DATA2 takes IMMEDIATE, 0 = register operand 2
- NEG_SEL  out  1  1 = ALU DATA2 takes two's complement of operand 2
- WRITEENABLE  out  1  register-file write strobe, one cycle
- BUSY  out  1  instruction in flight (state ≠ IDLE)
- ILLEGAL  out  1  one-cycle pulse on undefined opcode

## Operation
- Opcode decode: 0x00 loadi → ALUOP 000, IMM_SEL 1; 0x01 mov → 000; 0x02 add → 001; 0x03 sub → 001, NEG_SEL 1; 0x04 and → 010; 0x05 or → 011; all others illegal.
- Register fields use bits [2:0] only; bits [7:3] ignored. For loadi READREG2 = 0.
- States: IDLE, DECODE, EXEC, WRITEBACK.
- IDLE: INSTR_READY 1. VALID & READY at a rising edge latches INSTRUCTION → DECODE. VALID without READY is ignored (not queued).
- DECODE (1 cycle): all decoded outputs registered and driven. Legal opcode → EXEC, counter loaded with ADD_CYCLES (add/sub) or LOGIC_CYCLES (others). Illegal → ILLEGAL 1 for this cycle, ALUOP/IMM_SEL/NEG_SEL 0, → IDLE, no write.
- EXEC: counter decrements each cycle; at count 1 → WRITEBACK.
- WRITEBACK (1 cycle): WRITEENABLE 1 → IDLE.
- READREG1/2, WRITEREG, IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL held constant from DECODE through WRITEBACK; they retain last values in IDLE.
- Changes on INSTRUCTION/INSTR_VALID outside IDLE have no effect.

## Timing
- All outputs registered from CLK except INSTR_READY and BUSY, which are decoded from state.
- Reset values (RESET low, asynchronous): state IDLE, INSTR_READY 1, BUSY 0, WRITEENABLE 0, ILLEGAL 0, ALUOP 000, IMM_SEL 0, NEG_SEL 0, READREG1/2 0, WRITEREG 0, IMMEDIATE 0, counter 0.
- Reset mid-instruction: abort immediately; WRITEENABLE drops asynchronously; aborted instruction is never written.
- Latency, accept at edge N: DECODE cycle N+1, EXEC cycles N+2..N+1+k (k = selected cycle count), WRITEBACK cycle N+2+k, INSTR_READY high again from N+3+k.
- Throughput: one instruction per k+3 cycles (add: 5, logic/mov/loadi: 4 at defaults); illegal: 2 cycles.
- WRITEENABLE never high for more than one consecutive cycle; never high in DECODE, EXEC or IDLE.
- Back-to-back: VALID held high with a new instruction is accepted at the first edge where state is IDLE.

## Test plan
- Reset: drive RESET low mid-EXEC of an add → all outputs at reset values asynchronously, WRITEENABLE stays 0, INSTR_READY 1 after release.
- loadi 0x00_03_00_2A accepted at edge N → WRITEREG 3, IMMEDIATE 0x2A, ALUOP 000, IMM_SEL 1 from N+1; WRITEENABLE only in cycle N+3; READY at N+4.
- sub 0x03_05_01_02 → READREG1 1, READREG2 2, WRITEREG 5, ALUOP 001, NEG_SEL 1; WRITEENABLE only in cycle N+4 (ADD_CYCLES 2).
- Illegal 0x07_01_02_03 → ILLEGAL 1 for exactly cycle N+1, no WRITEENABLE, READY at N+2.
- Back-to-back and 0x04_01_02_03 then or 0x05_04_01_02 with VALID held high → second accepted 4 cycles after first, exactly two WRITEENABLE pulses (WRITEREG 1 then 4).
- Field masking: mov 0xFF-masked 0x01_F9_FA_FB → WRITEREG 1, READREG1 2, READREG2 3; INSTRUCTION toggled during EXEC leaves outputs unchanged.
